// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller with instruction, bypass and IDCODE registers.
// Drives the boundary-scan chain controls and muxes the selected serial path onto tdo.
module jtag_tap_controller #(
    parameter int unsigned IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    output logic       bsr_tdi,
    input  logic       bsr_tdo,
    output logic       bsr_clk,
    output logic       bsr_shift,
    output logic       bsr_update,
    output logic       bsr_mode,
    output logic [3:0] tap_state
);

    typedef enum logic [3:0] {
        StTestLogicReset = 4'hF,
        StRunTestIdle    = 4'hC,
        StSelectDr       = 4'h7,
        StCaptureDr      = 4'h6,
        StShiftDr        = 4'h2,
        StExit1Dr        = 4'h1,
        StPauseDr        = 4'h3,
        StExit2Dr        = 4'h0,
        StUpdateDr       = 4'h5,
        StSelectIr       = 4'h4,
        StCaptureIr      = 4'hE,
        StShiftIr        = 4'hA,
        StExit1Ir        = 4'h9,
        StPauseIr        = 4'hB,
        StExit2Ir        = 4'h8,
        StUpdateIr       = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OpExtest  = IR_WIDTH'(0);
    localparam logic [IR_WIDTH-1:0] OpSample  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OpIdcode  = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(1);

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_q, idcode_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;
    logic                bsr_update_q, bsr_update_d;
    logic                bsr_clk_en_q, bsr_clk_en_d;
    logic                sel_bsr, sel_idcode, sel_bypass;

    // Instruction decode; every opcode that is not recognised falls back to bypass.
    assign sel_bsr    = (ir_q == OpExtest) || (ir_q == OpSample);
    assign sel_idcode = (ir_q == OpIdcode);
    assign sel_bypass = !sel_bsr && !sel_idcode;

    // TAP state machine
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q <= StTestLogicReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTestLogicReset: state_d = tms ? StTestLogicReset : StRunTestIdle;
            StRunTestIdle:    state_d = tms ? StSelectDr       : StRunTestIdle;
            StSelectDr:       state_d = tms ? StSelectIr       : StCaptureDr;
            StCaptureDr:      state_d = tms ? StExit1Dr        : StShiftDr;
            StShiftDr:        state_d = tms ? StExit1Dr        : StShiftDr;
            StExit1Dr:        state_d = tms ? StUpdateDr       : StPauseDr;
            StPauseDr:        state_d = tms ? StExit2Dr        : StPauseDr;
            StExit2Dr:        state_d = tms ? StUpdateDr       : StShiftDr;
            StUpdateDr:       state_d = tms ? StSelectDr       : StRunTestIdle;
            StSelectIr:       state_d = tms ? StTestLogicReset : StCaptureIr;
            StCaptureIr:      state_d = tms ? StExit1Ir        : StShiftIr;
            StShiftIr:        state_d = tms ? StExit1Ir        : StShiftIr;
            StExit1Ir:        state_d = tms ? StUpdateIr       : StPauseIr;
            StPauseIr:        state_d = tms ? StExit2Ir        : StPauseIr;
            StExit2Ir:        state_d = tms ? StUpdateIr       : StShiftIr;
            StUpdateIr:       state_d = tms ? StSelectDr       : StRunTestIdle;
            default:          state_d = StTestLogicReset;
        endcase
    end

    // Capture/shift of the IR shift stage and the data registers on the rising edge
    always_comb begin
        ir_shift_d = ir_shift_q;
        bypass_d   = bypass_q;
        idcode_d   = idcode_q;

        if (state_q == StCaptureIr) begin
            ir_shift_d = IrCapture;
        end else if (state_q == StShiftIr) begin
            ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
        end

        if (sel_bypass) begin
            if (state_q == StCaptureDr) begin
                bypass_d = 1'b0;
            end else if (state_q == StShiftDr) begin
                bypass_d = tdi;
            end
        end

        if (sel_idcode) begin
            if (state_q == StCaptureDr) begin
                idcode_d = IDCODE_VAL;
            end else if (state_q == StShiftDr) begin
                idcode_d = {tdi, idcode_q[31:1]};
            end
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
            idcode_q   <= IDCODE_VAL;
        end else begin
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
        end
    end

    // Falling-edge side: active IR, tdo path and boundary-scan strobes
    always_comb begin
        ir_d         = ir_q;
        tdo_d        = 1'b0;
        tdo_en_d     = 1'b0;
        bsr_update_d = 1'b0;
        bsr_clk_en_d = 1'b0;

        if (state_q == StTestLogicReset) begin
            ir_d = OpIdcode;
        end else if (state_q == StUpdateIr) begin
            ir_d = ir_shift_q;
        end

        if (state_q == StShiftIr) begin
            tdo_d    = ir_shift_q[0];
            tdo_en_d = 1'b1;
        end else if (state_q == StShiftDr) begin
            tdo_en_d = 1'b1;
            if (sel_bsr) begin
                tdo_d = bsr_tdo;
            end else if (sel_idcode) begin
                tdo_d = idcode_q[0];
            end else begin
                tdo_d = bypass_q;
            end
        end

        bsr_update_d = (state_q == StUpdateDr) && sel_bsr;
        bsr_clk_en_d = ((state_q == StCaptureDr) || (state_q == StShiftDr)) && sel_bsr;
    end

    // The gate enable only moves while tck is low, so bsr_clk cannot glitch.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            ir_q         <= OpIdcode;
            tdo_q        <= 1'b0;
            tdo_en_q     <= 1'b0;
            bsr_update_q <= 1'b0;
            bsr_clk_en_q <= 1'b0;
        end else begin
            ir_q         <= ir_d;
            tdo_q        <= tdo_d;
            tdo_en_q     <= tdo_en_d;
            bsr_update_q <= bsr_update_d;
            bsr_clk_en_q <= bsr_clk_en_d;
        end
    end

    assign tdo        = tdo_q;
    assign tdo_en     = tdo_en_q;
    assign bsr_tdi    = tdi;
    assign bsr_clk    = tck & bsr_clk_en_q;
    assign bsr_shift  = (state_q == StShiftDr);
    assign bsr_update = bsr_update_q;
    assign bsr_mode   = (ir_q == OpExtest);
    assign tap_state  = state_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: directed scans plus a random tms/tdi walk,
// all compared against a table-driven reference model of the TAP and its registers.
module tb_jtag_tap_controller;

    localparam logic [31:0] IDCODE = 32'h1000_0001;
    localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SELDR = 4'h7, CAPDR = 4'h6;
    localparam logic [3:0] SHDR = 4'h2, EX1DR = 4'h1, PAUSEDR = 4'h3, EX2DR = 4'h0;
    localparam logic [3:0] UPDDR = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR = 4'hA;
    localparam logic [3:0] EX1IR = 4'h9, PAUSEIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD;

    logic       tck = 1'b0;
    logic       trst = 1'b1;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       bsr_tdo = 1'b0;
    logic       tdo, tdo_en, bsr_tdi, bsr_clk, bsr_shift, bsr_update, bsr_mode;
    logic [3:0] tap_state;

    int n_cmp = 0;
    int n_err = 0;
    int bsr_pulses = 0;
    int pulse_base = 0;

    // Reference model
    logic [3:0]  nx0 [16];
    logic [3:0]  nx1 [16];
    logic [3:0]  m_state, m_ir, m_irsh;
    logic        m_byp;
    logic [31:0] m_id;
    int          m_pulses;

    jtag_tap_controller dut (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .bsr_tdi    (bsr_tdi),
        .bsr_tdo    (bsr_tdo),
        .bsr_clk    (bsr_clk),
        .bsr_shift  (bsr_shift),
        .bsr_update (bsr_update),
        .bsr_mode   (bsr_mode),
        .tap_state  (tap_state)
    );

    always #5 tck = ~tck;

    always @(posedge bsr_clk) bsr_pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    function automatic logic is_bsr(input logic [3:0] ir);
        return (ir == 4'd0) || (ir == 4'd1);
    endfunction

    function automatic logic is_id(input logic [3:0] ir);
        return ir == 4'd2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse trst during a low phase and check the asynchronous reset values.
    task automatic pulse_trst();
        trst = 1'b0;
        #1;
        chk("rst_state", tap_state, TLR);
        chk("rst_tdo", tdo, 0);
        chk("rst_tdo_en", tdo_en, 0);
        chk("rst_bsr_update", bsr_update, 0);
        chk("rst_bsr_mode", bsr_mode, 0);
        chk("rst_bsr_clk", bsr_clk, 0);
        #1;
        trst = 1'b1;
        m_state    = TLR;
        m_ir       = 4'd2;
        m_irsh     = 4'd0;
        m_byp      = 1'b0;
        m_id       = IDCODE;
        m_pulses   = 0;
        pulse_base = bsr_pulses;
    endtask

    // One tck cycle: drive, advance the model on both edges, check in the low phase.
    task automatic clk(input logic m, input logic d);
        logic [3:0] s;
        logic       exp_tdo;
        tms     = m;
        tdi     = d;
        bsr_tdo = 1'($urandom_range(0, 1));
        @(posedge tck);
        s = m_state;
        if (s == CAPIR) m_irsh = 4'd1;
        if (s == SHIR)  m_irsh = (m_irsh >> 1) | (4'(d) << 3);
        if (s == CAPDR) begin
            m_byp = 1'b0;
            m_id  = IDCODE;
        end
        if (s == SHDR) begin
            m_byp = d;
            m_id  = (m_id >> 1) | (32'(d) << 31);
        end
        if ((s == CAPDR || s == SHDR) && is_bsr(m_ir)) m_pulses++;
        m_state = m ? nx1[s] : nx0[s];
        @(negedge tck);
        if (m_state == TLR)        m_ir = 4'd2;
        else if (m_state == UPDIR) m_ir = m_irsh;
        if (m_state == SHIR)      exp_tdo = m_irsh[0];
        else if (m_state == SHDR) exp_tdo = is_bsr(m_ir) ? bsr_tdo : (is_id(m_ir) ? m_id[0] : m_byp);
        else                      exp_tdo = 1'b0;
        #1;
        chk("tap_state", tap_state, m_state);
        chk("tdo", tdo, exp_tdo);
        chk("tdo_en", tdo_en, (m_state == SHIR) || (m_state == SHDR));
        chk("bsr_shift", bsr_shift, m_state == SHDR);
        chk("bsr_mode", bsr_mode, m_ir == 4'd0);
        chk("bsr_update", bsr_update, (m_state == UPDDR) && is_bsr(m_ir));
        chk("bsr_tdi", bsr_tdi, tdi);
        chk("bsr_clk_low", bsr_clk, 0);
        chk("bsr_clk_pulses", bsr_pulses - pulse_base, m_pulses);
    endtask

    // From TLR or RTI: 32-bit DR scan with tdi=0, ends in RTI.
    task automatic idcode_scan(output logic [31:0] word);
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        word = '0;
        for (int i = 0; i < 32; i++) begin
            clk(1'b0, 1'b0);
            word[i] = tdo;
        end
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    // From RTI or an Update state: load op into the IR, ends in UpdIR.
    task automatic ir_scan(input logic [3:0] op, output logic [3:0] cap);
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        cap[0] = tdo;
        for (int i = 0; i < 4; i++) begin
            clk(i == 3, op[i]);
            if (i < 3) cap[i + 1] = tdo;
        end
        clk(1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] word;
        logic [3:0]  cap;
        logic [3:0]  pat;
        logic [4:0]  obs;
        int          p0;
        string       walk;

        nx0[TLR]   = RTI;     nx1[TLR]   = TLR;
        nx0[RTI]   = RTI;     nx1[RTI]   = SELDR;
        nx0[SELDR] = CAPDR;   nx1[SELDR] = SELIR;
        nx0[CAPDR] = SHDR;    nx1[CAPDR] = EX1DR;
        nx0[SHDR]  = SHDR;    nx1[SHDR]  = EX1DR;
        nx0[EX1DR] = PAUSEDR; nx1[EX1DR] = UPDDR;
        nx0[PAUSEDR] = PAUSEDR; nx1[PAUSEDR] = EX2DR;
        nx0[EX2DR] = SHDR;    nx1[EX2DR] = UPDDR;
        nx0[UPDDR] = RTI;     nx1[UPDDR] = SELDR;
        nx0[SELIR] = CAPIR;   nx1[SELIR] = TLR;
        nx0[CAPIR] = SHIR;    nx1[CAPIR] = EX1IR;
        nx0[SHIR]  = SHIR;    nx1[SHIR]  = EX1IR;
        nx0[EX1IR] = PAUSEIR; nx1[EX1IR] = UPDIR;
        nx0[PAUSEIR] = PAUSEIR; nx1[PAUSEIR] = EX2IR;
        nx0[EX2IR] = SHIR;    nx1[EX2IR] = UPDIR;
        nx0[UPDIR] = RTI;     nx1[UPDIR] = SELDR;

        #1;
        pulse_trst();

        // Walk every arc of the state graph once
        walk = "10010001001011101011011000100101111010110111";
        for (int i = 0; i < walk.len(); i++) clk(walk[i] == "1", 1'($urandom_range(0, 1)));
        chk("walk_end_tlr", tap_state, TLR);

        // Five tms=1 clocks from RTI
        clk(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) clk(1'b1, 1'b0);
        chk("five_ones_tlr", tap_state, TLR);

        // IDCODE after reset
        pulse_trst();
        idcode_scan(word);
        chk("idcode_word", word, 32'h1000_0001);

        // IR capture pattern and bypass delay
        ir_scan(4'b1111, cap);
        chk("ir_capture", cap, 4'b0001);
        chk("bypass_mode", bsr_mode, 0);
        p0 = bsr_pulses;
        pat = 4'b1101;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        obs[0] = tdo;
        for (int i = 0; i < 4; i++) begin
            clk(1'b0, pat[i]);
            obs[i + 1] = tdo;
        end
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        chk("bypass_tdo_seq", obs, 5'b11010);
        chk("bypass_no_bsr_clk", bsr_pulses - p0, 0);

        // EXTEST: bsr_clk pulse count, pause, update strobe
        ir_scan(4'b0000, cap);
        chk("extest_mode", bsr_mode, 1);
        p0 = bsr_pulses;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) clk(1'b0, 1'($urandom_range(0, 1)));
        clk(1'b1, 1'b0);
        chk("extest_pulses", bsr_pulses - p0, 6);
        for (int i = 0; i < 4; i++) clk(1'b0, 1'b0);
        chk("pause_no_pulses", bsr_pulses - p0, 6);
        clk(1'b1, 1'b0);
        chk("ex2_no_update", bsr_update, 0);
        clk(1'b1, 1'b0);
        chk("upddr_update", bsr_update, 1);
        clk(1'b0, 1'b0);
        chk("rti_no_update", bsr_update, 0);

        // Undefined opcode behaves as bypass
        ir_scan(4'b0101, cap);
        chk("undef_mode", bsr_mode, 0);
        p0 = bsr_pulses;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) clk(1'b0, 1'($urandom_range(0, 1)));
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        chk("undef_no_bsr_clk", bsr_pulses - p0, 0);

        // Random walk, then forced return to TLR
        for (int i = 0; i < 300; i++) clk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) clk(1'b1, 1'($urandom_range(0, 1)));
        chk("random_then_tlr", tap_state, TLR);

        // Reset in the middle of a DR scan
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b1);
        chk("reach_shdr", tap_state, SHDR);
        for (int i = 0; i < 3; i++) clk(1'b0, 1'b1);
        pulse_trst();
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        idcode_scan(word);
        chk("idcode_after_abort", word, 32'h1000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
